net_io_ctrl: RTL and testbench

Host-side controller for the Hopfield `net` core. It receives an N-element probe state as a serial valid/ready stream and packs it into the flat `S` vector. It then runs `net` through `en`/`done`, captures `fullres`, and streams the N result elements back out over a second valid/ready port. It sits between the system bus adapter and `net`, replacing the static state register used in simulation; the weight matrix path is untouched.

---
 rtl/hopf_pkg.sv | 14 +
 rtl/vec_shift_out.sv | 62 ++++++
 rtl/net_io_ctrl.sv | 150 +++++++++++++++
 tb/tb_net_io_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hopf_pkg.sv
// Shared Hopfield definitions: default network dimensions and the host I/O FSM state enum.
package hopf_pkg;

    localparam int unsigned HOPF_N    = 81;
    localparam int unsigned HOPF_SIZE = 16;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } io_state_t;

endpackage

// File: rtl/vec_shift_out.sv
// Result vector register with an indexed element mux.
// The mux drives a valid/ready output stream.
module vec_shift_out
    import hopf_pkg::*;
#(
    parameter int unsigned N    = HOPF_N,
    parameter int unsigned SIZE = HOPF_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              active,
    input  logic [N*SIZE-1:0] fullres,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_data,
    output logic              last_c
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][SIZE-1:0] res_q, res_d;
    logic [IW-1:0]          idx_q, idx_d, idx_nxt_c;
    logic [SIZE-1:0]        data_q, data_d;
    logic                   fire_c;

    // out_data is preloaded with the next element so it is valid on the first SEND cycle.
    always_comb begin
        res_d     = res_q;
        idx_d     = idx_q;
        data_d    = data_q;
        fire_c    = active && out_ready;
        last_c    = fire_c && (idx_q == IW'(N - 1));
        idx_nxt_c = idx_q + IW'(1);
        if (capture) begin
            res_d  = fullres;
            idx_d  = '0;
            data_d = fullres[SIZE-1:0];
        end else if (fire_c) begin
            if (last_c) begin
                idx_d = '0;
            end else begin
                idx_d  = idx_nxt_c;
                data_d = res_q[idx_nxt_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            res_q  <= res_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: rtl/net_io_ctrl.sv
// Host-side stream controller for the Hopfield net core: serial load of S, run, capture, serial readback.
// Optional run watchdog enabled by `define NET_IO_TIMEOUT_EN.
module net_io_ctrl
    import hopf_pkg::*;
#(
    parameter int unsigned N       = HOPF_N,
    parameter int unsigned SIZE    = HOPF_SIZE,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SIZE-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*SIZE-1:0] S,
    output logic              en,
    input  logic [N*SIZE-1:0] fullres,
    input  logic              done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    io_state_t              state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N-1:0][SIZE-1:0] s_q, s_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   capture_c;
    logic                   last_c;

`ifdef NET_IO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic          timeout_unused;
    assign timeout_unused = (TIMEOUT == 0);
`endif

    // Handshake readiness depends on state only, never on the opposite handshake input.
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == SEND);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        s_d       = s_q;
        capture_c = 1'b0;
`ifdef NET_IO_TIMEOUT_EN
        cnt_d     = '0;
        err_d     = err_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    s_d[idx_q] = in_data;
`ifdef NET_IO_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            RUN: begin
                if (done) begin
                    state_d = CAPTURE;
                end
`ifdef NET_IO_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = LOAD;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            CAPTURE: begin
                capture_c = 1'b1;
                idx_d     = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (last_c) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        // Registered strobes follow the next state so they align with the state they describe.
        en_d   = (state_d == RUN);
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            s_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef NET_IO_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
`ifdef NET_IO_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    vec_shift_out #(
        .N    (N),
        .SIZE (SIZE)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture_c),
        .active    (out_valid),
        .fullres   (fullres),
        .out_ready (out_ready),
        .out_data  (out_data),
        .last_c    (last_c)
    );

    assign S    = s_q;
    assign en   = en_q;
    assign busy = busy_q;
`ifdef NET_IO_TIMEOUT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_net_io_ctrl.sv
// Bench for net_io_ctrl (N=4, SIZE=16): random streams against a scoreboard and a behavioural net model.
module tb_net_io_ctrl;

    localparam int unsigned N       = 4;
    localparam int unsigned SIZE    = 16;
    localparam int unsigned TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic [SIZE-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*SIZE-1:0] S;
    logic              en;
    logic [N*SIZE-1:0] fullres;
    logic              done;
    logic              busy;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [SIZE-1:0] exp_q[$];

    net_io_ctrl #(.N(N), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .en        (en),
        .fullres   (fullres),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural net: done after 10 cycles of en, result = element-wise negation of S.
    int   en_cnt;
    logic early_done;
    logic no_done;
    always @(posedge clk) begin
        if (rst || !en) en_cnt <= 0;
        else            en_cnt <= en_cnt + 1;
    end
    assign done = !no_done && (early_done || (en && en_cnt >= 9));
    always_comb begin
        for (int k = 0; k < N; k++) fullres[k*SIZE +: SIZE] = -S[k*SIZE +: SIZE];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output scoreboard: each handshake must deliver the next expected element.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("in_ready_in_send", 64'(in_ready), 64'd0);
            if (out_ready) begin
                if (exp_q.size() == 0) check("out_extra", 64'd1, 64'd0);
                else                   check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // Feed one frame; gap: 0 back-to-back, 1 idle between beats, 2 random idles. Ends at a negedge.
    task automatic send_frame(input logic [SIZE-1:0] v [N], input int gap);
        logic [N*SIZE-1:0] exp_s = '0;
        for (int k = 0; k < N; k++) begin
            if (k > 0 && (gap == 1 || (gap == 2 && $urandom_range(1) == 1))) begin
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("en_idle_load", 64'(en), 64'd0);
            end
            in_valid = 1'b1;
            in_data  = v[k];
            exp_s[k*SIZE +: SIZE] = v[k];
            exp_q.push_back(-v[k]);
            check("in_ready_load", 64'(in_ready), 64'd1);
            check("en_load", 64'(en), 64'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = SIZE'($urandom);
            @(negedge clk);
            check("err_after_beat", 64'(err), 64'd0);
            if (k == N - 1) begin
                check("en_after_load", 64'(en), 64'd1);
                check("busy_after_load", 64'(busy), 64'd1);
                check("in_ready_run", 64'(in_ready), 64'd0);
                check("s_packed", 64'(S), 64'(exp_s));
                check("s_elem3", 64'(S[3*SIZE +: SIZE]), 64'(v[3]));
            end
        end
    endtask

    // Collect outputs; mode 0 full rate, 1 random ready and junk input, 2 five-cycle stall after 2 beats.
    task automatic drain(input int mode);
        int cyc   = 0;
        int stall = 0;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) break;
            if (mode == 1) begin
                out_ready = 1'($urandom_range(1));
                in_valid  = 1'($urandom_range(1));
                in_data   = SIZE'($urandom);
            end else if (mode == 2 && (N - exp_q.size()) == 2 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                @(negedge clk);
                check("bp_valid", 64'(out_valid), 64'd1);
                check("bp_hold", 64'(out_data), 64'(exp_q[0]));
            end else begin
                out_ready = 1'b1;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
        check("in_ready_after_send", 64'(in_ready), 64'd1);
        check("out_valid_after_send", 64'(out_valid), 64'd0);
        check("busy_after_send", 64'(busy), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s"}, 64'(S), 64'd0);
        check({tag, "_en"}, 64'(en), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [SIZE-1:0] v [N];
        logic [SIZE-1:0] r [N];
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        early_done = 1'b0;
        no_done    = 1'b0;
        @(negedge clk);
        check_idle("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        v = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
        send_frame(v, 0);
        drain(0);

        send_frame(v, 0);
        drain(2);

        r = '{16'h1234, 16'h8000, 16'h7FFF, 16'hBEEF};
        send_frame(r, 1);
        drain(1);

        // Reset mid-run discards the frame
        send_frame(v, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrun_rst");
        for (int k = 0; k < N; k++) r[k] = SIZE'($urandom);
        send_frame(r, 2);
        drain(1);

        // done already high when RUN is entered
        early_done = 1'b1;
        send_frame(r, 0);
        @(negedge clk);
        check("early_en_one_cycle", 64'(en), 64'd0);
        check("early_capture_busy", 64'(busy), 64'd1);
        check("early_capture_no_valid", 64'(out_valid), 64'd0);
        early_done = 1'b0;
        @(negedge clk);
        check("early_send_valid", 64'(out_valid), 64'd1);
        drain(0);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < N; k++) r[k] = SIZE'($urandom);
            send_frame(r, 2);
            drain(1);
        end

`ifdef NET_IO_TIMEOUT_EN
        begin
            int c = 1;
            no_done = 1'b1;
            send_frame(v, 0);
            exp_q.delete();
            while (c < 50) begin
                @(negedge clk);
                if (!en) break;
                c++;
            end
            check("wd_en_cycles", 64'(c), 64'(TIMEOUT));
            check("wd_err", 64'(err), 64'd1);
            check("wd_in_ready", 64'(in_ready), 64'd1);
            check("wd_busy", 64'(busy), 64'd0);
            repeat (3) begin
                @(negedge clk);
                check("wd_no_send", 64'(out_valid), 64'd0);
                check("wd_err_sticky", 64'(err), 64'd1);
            end
            no_done = 1'b0;
            send_frame(v, 0);
            drain(0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
